cuadrador_16_32: RTL and testbench

- Sequential inverse of the 32/16 square-root unit. Takes a 16-bit root Q and 17-bit remainder R, and rebuilds the radicand Y = Q*Q + R.
- Uses an MSB-first shift-add loop with the same START/FIN level handshake as the radicator.
- Sits beside the radicator in the verilog_aplication datapath. Used for root self-check and for regenerating squared magnitudes.

---
 rtl/cuadrador_pkg.sv | 27 ++
 rtl/paso_cuadrador.sv | 36 +++
 rtl/cuadrador_16_32.sv | 88 ++++++++
 tb/tb_cuadrador_16_32.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cuadrador_pkg.sv
// Shared constants and state encoding for the cuadrador_16_32 radicand rebuilder.
// CUADRADOR_RADIX4_EN selects two multiplier bits per calc iteration.
package cuadrador_pkg;

    localparam int N_RAIZ  = 16;
    localparam int ITER_R2 = 16;
    localparam int ITER_R4 = 8;

`ifdef CUADRADOR_RADIX4_EN
    localparam int BITS_PASO = 2;
    localparam int ITER      = ITER_R4;
`else
    localparam int BITS_PASO = 1;
    localparam int ITER      = ITER_R2;
`endif

    // Sized for the slower radix-2 loop so both builds share one counter width.
    localparam int CONT_W = $clog2(ITER_R2);

    typedef enum logic [1:0] {
        idle,
        calc,
        suma,
        finali
    } estado_t;

endpackage

// File: rtl/paso_cuadrador.sv
// One combinational shift-add step of the MSB-first squaring loop.
// CUADRADOR_RADIX4_EN consumes two multiplier bits per step instead of one.
module paso_cuadrador
    import cuadrador_pkg::*;
#(
    parameter int N = N_RAIZ
) (
    input  logic [2*N-1:0]       acc_i,
    input  logic [N-1:0]         m_i,
    input  logic [BITS_PASO-1:0] bits_i,
    output logic [2*N-1:0]       acc_o
);

    logic [2*N-1:0] m_ext;
    assign m_ext = {{N{1'b0}}, m_i};

`ifdef CUADRADOR_RADIX4_EN
    logic [2*N-1:0] parcial;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        parcial = '0;
        case (bits_i)
            2'd1:    parcial = m_ext;
            2'd2:    parcial = m_ext << 1;
            2'd3:    parcial = m_ext + (m_ext << 1);
            default: parcial = '0;
        endcase
    end

    assign acc_o = (acc_i << 2) + parcial;
`else
    assign acc_o = (acc_i << 1) + (bits_i[0] ? m_ext : '0);
`endif

endmodule

// File: rtl/cuadrador_16_32.sv
// Sequential rebuild of a radicand Y = Q*Q + R with a START/FIN level handshake.
// Iteration radix follows CUADRADOR_RADIX4_EN (see cuadrador_pkg).
module cuadrador_16_32
    import cuadrador_pkg::*;
#(
    parameter int N = N_RAIZ
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic [N-1:0]   Q,
    input  logic [N:0]     R,
    output logic           FIN,
    output logic [2*N-1:0] Y,
    output logic           OVF
);

    estado_t          estado_q;
    logic [CONT_W-1:0] cont_q;
    logic [2*N-1:0]   acc_q;
    logic [2*N-1:0]   acc_d;
    logic [N-1:0]     m_q;
    logic [N-1:0]     b_q;
    logic [N:0]       r_q;
    logic [2*N-1:0]   y_q;
    logic             ovf_q;

    paso_cuadrador #(.N(N)) u_paso (
        .acc_i  (acc_q),
        .m_i    (m_q),
        .bits_i (b_q[N-1 -: BITS_PASO]),
        .acc_o  (acc_d)
    );

    // NOTE: the operand registers are few flops, so they are reset too; an abort leaves nothing stale.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            estado_q <= idle;
            cont_q   <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case (estado_q)
                idle: begin
                    if (START) begin
                        m_q      <= Q;
                        b_q      <= Q;
                        r_q      <= R;
                        acc_q    <= '0;
                        cont_q   <= '0;
                        y_q      <= '0;
                        ovf_q    <= 1'b0;
                        estado_q <= calc;
                    end
                end
                calc: begin
                    acc_q  <= acc_d;
                    b_q    <= b_q << BITS_PASO;
                    cont_q <= cont_q + 1'b1;
                    if (cont_q == CONT_W'(ITER - 1)) begin
                        estado_q <= suma;
                    end
                end
                suma: begin
                    {ovf_q, y_q} <= {1'b0, acc_q} + {{N{1'b0}}, r_q};
                    estado_q     <= finali;
                end
                finali: begin
                    // Level handshake: a held START parks here until it drops.
                    if (!START) begin
                        estado_q <= idle;
                    end
                end
                default: estado_q <= idle;
            endcase
        end
    end

    assign FIN = (estado_q == finali);
    assign Y   = y_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_cuadrador_16_32.sv
// Scoreboard bench for cuadrador_16_32: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them on every FIN rising edge.
module tb_cuadrador_16_32;

`ifdef CUADRADOR_RADIX4_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 17;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] Q;
    logic [16:0] R;
    logic        FIN;
    logic [31:0] Y;
    logic        OVF;

    cuadrador_16_32 dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .Q     (Q),
        .R     (R),
        .FIN   (FIN),
        .Y     (Y),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        int unsigned cyc0;
        string       name;
    } esperado_t;

    esperado_t   sb[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic        fin_prev = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: one pop per FIN rising edge, also checking the handshake latency.
    always @(negedge CLK) begin
        if (RESET && FIN && !fin_prev) begin
            if (sb.size() == 0) begin
                check("unexpected FIN", 64'd1, 64'd0);
            end else begin
                esperado_t e;
                e = sb.pop_front();
                check({e.name, " Y"}, 64'(Y), 64'(e.y));
                check({e.name, " OVF"}, 64'(OVF), 64'(e.ovf));
                check({e.name, " latency"}, 64'(cyc - e.cyc0), 64'(LAT));
            end
        end
        fin_prev = FIN;
    end

    task automatic issue(input logic [15:0] q, input logic [16:0] r,
                         input logic [31:0] y, input logic ovf, input string name);
        esperado_t e;
        @(negedge CLK);
        Q     = q;
        R     = r;
        START = 1'b1;
        e.y    = y;
        e.ovf  = ovf;
        e.cyc0 = cyc + 1;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_fin(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (FIN) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, " FIN timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [15:0] q, input logic [16:0] r,
                          input logic [31:0] y, input logic ovf, input string name);
        issue(q, r, y, ovf, name);
        wait_fin(name);
        START = 1'b0;
        @(negedge CLK);
        check({name, " FIN drop"}, 64'(FIN), 64'd0);
    endtask

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] q = '0;
        logic [15:0] t;
        for (int b = 15; b >= 0; b--) begin
            t = q | (16'd1 << b);
            if ((64'(t) * 64'(t)) <= 64'(x)) q = t;
        end
        return q;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        logic [15:0] qq;
        logic [16:0] rr;

        RESET = 1'b0;
        START = 1'b0;
        Q     = '0;
        R     = '0;
        #1;
        check("reset FIN", 64'(FIN), 64'd0);
        check("reset Y", 64'(Y), 64'd0);
        check("reset OVF", 64'(OVF), 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        // 3*3+2 with START held through finali: no restart, FIN and Y hold.
        issue(16'h0003, 17'h00002, 32'h0000000B, 1'b0, "q3r2");
        wait_fin("q3r2");
        repeat (3) begin
            @(negedge CLK);
            check("hold FIN", 64'(FIN), 64'd1);
            check("hold Y", 64'(Y), 64'h0000000B);
        end
        START = 1'b0;
        @(negedge CLK);
        check("q3r2 FIN drop", 64'(FIN), 64'd0);
        check("idle Y hold", 64'(Y), 64'h0000000B);

        run_op(16'hFFFF, 17'h1FFFE, 32'hFFFFFFFF, 1'b0, "max valid");
        run_op(16'hFFFF, 17'h1FFFF, 32'h00000000, 1'b1, "overflow");
        run_op(16'h8000, 17'h00000, 32'h40000000, 1'b0, "q8000");
        run_op(16'h0000, 17'h00000, 32'h00000000, 1'b0, "zero");

        // Abort during calc iteration 5: nothing is expected from this request.
        issue(16'h1234, 17'h00005, 32'h014B5A95, 1'b0, "aborted");
        repeat (6) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("abort FIN", 64'(FIN), 64'd0);
        check("abort Y", 64'(Y), 64'd0);
        check("abort OVF", 64'(OVF), 64'd0);
        sb.delete();
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        run_op(16'h0100, 17'h00010, 32'h00010010, 1'b0, "after reset");

        // START toggled and operands changed mid-calc: the latched operands win.
        issue(16'h00FF, 17'h00003, 32'h0000FE04, 1'b0, "toggle");
        repeat (3) @(negedge CLK);
        START = 1'b0;
        Q     = 16'hFFFF;
        R     = 17'h1FFFF;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_fin("toggle");
        @(negedge CLK);
        check("toggle FIN drop", 64'(FIN), 64'd0);

        // Loopback against an integer square-root model.
        for (int i = 0; i < 1000; i++) begin
            x  = $urandom;
            qq = isqrt(x);
            rr = 17'(x - 32'(qq) * 32'(qq));
            run_op(qq, rr, x, 1'b0, "loopback");
        end

        repeat (4) @(negedge CLK);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
